rf_wb_arbiter: RTL and testbench

- Owns the single write port of the 32x32 register file (rf_riscv).
- Clears registers x1..x31 to zero after reset.
- Then arbitrates two writeback requesters, ALU/CSR result and LSU load data, onto that port using valid/ready handshakes and round-robin priority.
- Sits between the execute/memory stages and rf_riscv; the RF read ports are not touched.

---
 rtl/rf_wb_arbiter_pkg.sv | 15 +
 rtl/rf_wb_arbiter_rr_arb2.sv | 31 +++
 rtl/rf_wb_arbiter.sv | 98 +++++++++
 tb/tb_rf_wb_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and sizes for the register-file writeback path.
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;

  typedef enum logic {S_CLEAR, S_RUN} rf_wb_state_t;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; on a conflict the requester not granted last wins.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // Index of the requester granted most recently; resets to 0 so req[1] wins the first conflict.
  logic last_p0;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_p0 ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_p0 <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      last_p0 <= gnt[1];
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port owner: zeroes x1..x31 after reset, then arbitrates ALU and LSU writebacks.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  alu_valid_i,
  input  logic [ADDR_WIDTH-1:0] alu_addr_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  output logic                  alu_ready_o,
  input  logic                  lsu_valid_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_data_i,
  output logic                  lsu_ready_o,
  output logic                  write_enable_o,
  output logic [ADDR_WIDTH-1:0] write_addr_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic                  init_busy_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  rf_wb_state_t          state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  busy_p1;
  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  logic                  run_en;
  logic [1:0]            req;
  logic [1:0]            gnt;
  logic                  xfer;
  rf_wb_req_t            sel;

  // Grants open only once the last clear write has left the output register.
  assign run_en = (state == S_RUN) && !busy_p1;
  assign req    = {lsu_valid_i, alu_valid_i} & {2{run_en}};
  assign xfer   = |gnt;

  rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req     (req),
    .advance (xfer),
    .gnt     (gnt)
  );

  always_comb begin
    sel.addr = alu_addr_i;
    sel.data = alu_data_i;
    if (gnt[1]) begin
      sel.addr = lsu_addr_i;
      sel.data = lsu_data_i;
    end
  end

  // Stage p1: registered write port
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
      cnt     <= ADDR_WIDTH'(1);
      busy_p1 <= (CLEAR_ON_RESET != 0);
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      busy_p1 <= (state == S_CLEAR);
      vld_p1  <= 1'b0;
      if (state == S_CLEAR) begin
        vld_p1  <= 1'b1;
        addr_p1 <= cnt;
        data_p1 <= '0;
        cnt     <= cnt + 1'b1;
        if (cnt == LAST_ADDR) begin
          state <= S_RUN;
        end
      end else if (xfer && (sel.addr != '0)) begin
        // x0 is hardwired to zero, so an accepted write to it is swallowed here.
        vld_p1  <= 1'b1;
        addr_p1 <= sel.addr;
        data_p1 <= sel.data;
      end
    end
  end

  assign alu_ready_o    = gnt[0];
  assign lsu_ready_o    = gnt[1];
  assign write_enable_o = vld_p1;
  assign write_addr_o   = addr_p1;
  assign write_data_o   = data_p1;
  assign init_busy_o    = busy_p1;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scoreboard bench for rf_wb_arbiter with a behavioural register file on the write port.
module tb_rf_wb_arbiter;

  typedef struct {
    logic        we;
    logic        hold;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        init_busy;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [4:0]  last_a;
  logic [31:0] last_d;
  logic [31:0] rf [32];
  logic        rf_seeded = 1'b0;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .alu_valid_i    (alu_valid),
    .alu_addr_i     (alu_addr),
    .alu_data_i     (alu_data),
    .alu_ready_o    (alu_ready),
    .lsu_valid_i    (lsu_valid),
    .lsu_addr_i     (lsu_addr),
    .lsu_data_i     (lsu_data),
    .lsu_ready_o    (lsu_ready),
    .write_enable_o (write_enable),
    .write_addr_o   (write_addr),
    .write_data_o   (write_data),
    .init_busy_o    (init_busy)
  );

  // Behavioural rf_riscv: starts full of garbage so the clear has something to erase.
  always @(posedge clk) begin
    if (!rf_seeded) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'hDEAD_BEEF;
      rf_seeded <= 1'b1;
    end else if (write_enable) begin
      rf[write_addr] <= write_data;
    end
  end

  function automatic logic [31:0] rf_read(input int idx);
    return (idx == 0) ? 32'h0 : rf[idx];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("write_enable", {31'b0, write_enable}, {31'b0, e.we});
      check("init_busy", {31'b0, init_busy}, {31'b0, e.busy});
      if (e.we || e.hold) begin
        check("write_addr", {27'b0, write_addr}, {27'b0, e.addr});
        check("write_data", write_data, e.data);
      end
    end
  endtask

  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic ear, input logic elr,
                      input logic ewe, input logic ehold, input logic [4:0] ea,
                      input logic [31:0] ed, input logic ebusy);
    exp_t e;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
    @(negedge clk);
    check("alu_ready", {31'b0, alu_ready}, {31'b0, ear});
    check("lsu_ready", {31'b0, lsu_ready}, {31'b0, elr});
    pop_check();
    if (ewe) begin
      last_a = ea;
      last_d = ed;
    end
    e.we = ewe; e.hold = ehold; e.addr = last_a; e.data = last_d; e.busy = ebusy;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic ebusy);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0, ebusy);
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_addr = '0; lsu_data = '0;
    @(negedge clk);
    pop_check();
    exp_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_write_enable", {31'b0, write_enable}, 32'h0);
    check("rst_write_addr", {27'b0, write_addr}, 32'h0);
    check("rst_write_data", write_data, 32'h0);
    check("rst_init_busy", {31'b0, init_busy}, 32'h1);
    check("rst_alu_ready", {31'b0, alu_ready}, 32'h0);
    check("rst_lsu_ready", {31'b0, lsu_ready}, 32'h0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    last_a = '0;
    last_d = '0;
  endtask

  task automatic run_clear();
    for (int i = 1; i <= 31; i++) begin
      step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'(i), 32'h0, 1'b1);
    end
    idle(1'b0);
    idle(1'b0);
  endtask

  task automatic check_rf_zero();
    for (int i = 1; i < 32; i++) check("rf_cleared", rf_read(i), 32'h0);
  endtask

  initial begin
    rst_ni = 1'b0;
    last_a = '0;
    last_d = '0;

    apply_reset();
    run_clear();
    check_rf_zero();

    // single ALU writeback
    step(1'b1, 5'd5, 32'hAAAA_AAAA, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 32'hAAAA_AAAA, 1'b0);
    idle(1'b0);
    idle(1'b0);

    // sustained conflict: LSU first, then strict alternation
    for (int k = 0; k < 6; k++) begin
      logic lt;
      lt = (k % 2) == 0;
      step(1'b1, 5'd1, 32'd1, 1'b1, 5'd2, 32'd2, !lt, lt, 1'b1, 1'b0,
           lt ? 5'd2 : 5'd1, lt ? 32'd2 : 32'd1, 1'b0);
    end
    idle(1'b0);

    // LSU write to x0 is accepted, dropped, and still moves the pointer
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
    step(1'b1, 5'd7, 32'd7, 1'b1, 5'd8, 32'd8, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 32'd7, 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'd8, 1'b0, 1'b1, 1'b1, 1'b0, 5'd8, 32'd8, 1'b0);
    idle(1'b0);

    // LSU back-to-back
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'd3, 1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 32'd3, 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'd2, 1'b0, 1'b1, 1'b1, 1'b0, 5'd2, 32'd2, 1'b0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'd1, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3, 32'd1, 1'b0);
    idle(1'b0);
    idle(1'b0);
    check("rf_x1", rf_read(1), 32'd3);
    check("rf_x2", rf_read(2), 32'd2);
    check("rf_x3", rf_read(3), 32'd1);
    check("rf_x5", rf_read(5), 32'hAAAA_AAAA);
    check("rf_x7", rf_read(7), 32'd7);
    check("rf_x8", rf_read(8), 32'd8);

    // clear aborted at addr 10 while an ALU request waits, then restarted from addr 1
    apply_reset();
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 5'(i), 32'h0, 1'b1);
    end
    apply_reset();
    run_clear();
    check_rf_zero();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
